// File: rtl/twowire_dtm_connect_seq.sv
// Two-Wire DTM connect/disconnect engine: hunts DIO for the magic sequence, checks the
// multidrop address, and drops the link on line reset or on a command-layer request.
//
// state   | meaning
// ST_IDLE | hunting for the magic sequence in the sliding window
// ST_ADDR | collecting the multidrop address, LSB first
// ST_CONN | connected; watching for a line reset or a disconnect command
module twowire_dtm_connect_seq #(
    parameter int unsigned          MAGIC_LEN = 32,
    parameter logic [MAGIC_LEN-1:0] MAGIC     = 32'ha5c3_96e1,
    parameter int unsigned          ADDR_W    = 4,
    parameter int unsigned          DISC_LEN  = 16
) (
    input  logic              dck,
    input  logic              drst_n,
    input  logic              di_q,
    input  logic [ADDR_W-1:0] mdropaddr,
    input  logic              cmd_disconnect,
    output logic              connected,
    output logic              connect_now,
    output logic              disconnect_now,
    output logic              addr_mismatch
);

    localparam int unsigned CNT_W = $clog2(ADDR_W + 1);
    localparam int unsigned OC_W  = $clog2(DISC_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_CONN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [MAGIC_LEN-1:0] sr_q, sr_d, sr_shift;
    logic [ADDR_W-1:0]    addr_q, addr_d, addr_shift;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [OC_W-1:0]      ones_q, ones_d;
    logic                 cn_d, dn_d, am_d;
    logic                 line_reset;

    // Newest bit enters at the MSB so the oldest bit of the window sits in the LSB.
    assign sr_shift   = MAGIC_LEN'({di_q, sr_q} >> 1);
    assign addr_shift = ADDR_W'({di_q, addr_q} >> 1);
    assign line_reset = di_q && (ones_q == OC_W'(DISC_LEN - 1));

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        addr_d    = addr_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        cn_d      = 1'b0;
        dn_d      = 1'b0;
        am_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sr_d = sr_shift;
                if (sr_shift == MAGIC) begin
                    state_d   = ST_ADDR;
                    sr_d      = '0;
                    addr_d    = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_ADDR: begin
                addr_d    = addr_shift;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                    bit_cnt_d = '0;
                    if (addr_shift == mdropaddr) begin
                        state_d = ST_CONN;
                        ones_d  = '0;
                        cn_d    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        sr_d    = '0;
                        am_d    = 1'b1;
                    end
                end
            end
            ST_CONN: begin
                if (!di_q) begin
                    ones_d = '0;
                end else if (ones_q != OC_W'(DISC_LEN)) begin
                    ones_d = ones_q + OC_W'(1);
                end
                // Both causes collapse into one transition, hence a single pulse.
                if (line_reset || cmd_disconnect) begin
                    state_d = ST_IDLE;
                    ones_d  = '0;
                    sr_d    = '0;
                    dn_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sr_d    = '0;
            end
        endcase
    end

    always_ff @(posedge dck) begin
        if (!drst_n) begin
            state_q        <= ST_IDLE;
            sr_q           <= '0;
            addr_q         <= '0;
            bit_cnt_q      <= '0;
            ones_q         <= '0;
            connected      <= 1'b0;
            connect_now    <= 1'b0;
            disconnect_now <= 1'b0;
            addr_mismatch  <= 1'b0;
        end else begin
            state_q        <= state_d;
            sr_q           <= sr_d;
            addr_q         <= addr_d;
            bit_cnt_q      <= bit_cnt_d;
            ones_q         <= ones_d;
            connected      <= (state_d == ST_CONN);
            connect_now    <= cn_d;
            disconnect_now <= dn_d;
            addr_mismatch  <= am_d;
        end
    end

endmodule

// File: tb/tb_twowire_dtm_connect_seq.sv
// Bench for twowire_dtm_connect_seq: vector table, directed corner sequences and
// randomized episodes, all checked against a queue-based reference model.
module tb_twowire_dtm_connect_seq;

    localparam int unsigned MAGIC_LEN = 32;
    localparam logic [31:0] MAGIC_V   = 32'ha5c3_96e1;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DISC_LEN  = 16;

    logic       dck = 1'b0;
    logic       drst_n = 1'b0;
    logic       di_q = 1'b0;
    logic [3:0] mdrop = 4'h0;
    logic       cmd_disconnect = 1'b0;
    logic       connected, connect_now, disconnect_now, addr_mismatch;

    int vectors = 0;
    int miscompares = 0;

    twowire_dtm_connect_seq #(
        .MAGIC_LEN(MAGIC_LEN),
        .MAGIC    (MAGIC_V),
        .ADDR_W   (ADDR_W),
        .DISC_LEN (DISC_LEN)
    ) dut (
        .dck           (dck),
        .drst_n        (drst_n),
        .di_q          (di_q),
        .mdropaddr     (mdrop),
        .cmd_disconnect(cmd_disconnect),
        .connected     (connected),
        .connect_now   (connect_now),
        .disconnect_now(disconnect_now),
        .addr_mismatch (addr_mismatch)
    );

    always #5 dck = ~dck;

    // Reference model: phase 0 = hunting, 1 = address, 2 = connected.
    int  m_phase = 0;
    bit  m_hist[$];
    bit  m_abits[$];
    int  m_run = 0;
    bit  e_conn = 0, e_cn = 0, e_dn = 0, e_am = 0;

    function automatic void clear_hist();
        m_hist.delete();
        for (int i = 0; i < MAGIC_LEN; i++) m_hist.push_back(1'b0);
    endfunction

    function automatic bit window_is_magic();
        logic [31:0] mv = MAGIC_V;
        for (int i = 0; i < MAGIC_LEN; i++)
            if (m_hist[i] != mv[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_edge(bit rst_n, bit di, bit cmd, logic [3:0] ma);
        int v;
        e_cn = 0; e_dn = 0; e_am = 0;
        if (!rst_n) begin
            m_phase = 0; m_run = 0; m_abits.delete(); clear_hist();
            e_conn = 0;
            return;
        end
        case (m_phase)
            0: begin
                m_hist.push_back(di);
                void'(m_hist.pop_front());
                if (window_is_magic()) begin
                    m_phase = 1; clear_hist(); m_abits.delete();
                end
            end
            1: begin
                m_abits.push_back(di);
                if (m_abits.size() == ADDR_W) begin
                    v = 0;
                    for (int i = 0; i < ADDR_W; i++) v += int'(m_abits[i]) << i;
                    if (v == int'(ma)) begin
                        m_phase = 2; m_run = 0; e_cn = 1;
                    end else begin
                        m_phase = 0; clear_hist(); e_am = 1;
                    end
                    m_abits.delete();
                end
            end
            default: begin
                m_run = di ? m_run + 1 : 0;
                if (m_run >= DISC_LEN || cmd) begin
                    m_phase = 0; m_run = 0; clear_hist(); e_dn = 1;
                end
            end
        endcase
        e_conn = (m_phase == 2);
    endfunction

    function automatic logic [3:0] outs();
        return {connected, connect_now, disconnect_now, addr_mismatch};
    endfunction

    task automatic check(string name, logic [3:0] act, logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got {conn,cn,dn,am}=%b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(bit di, bit cmd, bit rst_n);
        di_q = di; cmd_disconnect = cmd; drst_n = rst_n;
        @(posedge dck);
        model_edge(rst_n, di, cmd, mdrop);
        #1;
        check("model", outs(), {e_conn, e_cn, e_dn, e_am});
    endtask

    task automatic send_bits(logic [63:0] v, int lo, int hi);
        for (int i = lo; i <= hi; i++) tick(v[i], 1'b0, 1'b1);
    endtask

    typedef struct {
        bit         rst_n;
        bit         di;
        bit         cmd;
        logic [3:0] ma;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [63:0] mw;
        logic [3:0]  a;
        int          n;

        clear_hist();

        // Table: reset, idle command, noise, MAGIC, address 3, hold.
        a = 4'h3;
        mw = 64'(MAGIC_V);
        tbl.push_back('{1'b0, 1'b0, 1'b0, 4'h3, 4'b0000});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 4'h3, 4'b0000});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 4'h3, 4'b0000});
        for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 1'($urandom), 1'b0, 4'h3, 4'b0000});
        for (int i = 0; i < MAGIC_LEN; i++) tbl.push_back('{1'b1, mw[i], 1'b0, 4'h3, 4'b0000});
        for (int i = 0; i < ADDR_W; i++)
            tbl.push_back('{1'b1, a[i], 1'b0, 4'h3, (i == ADDR_W - 1) ? 4'b1100 : 4'b0000});
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 1'b0, 1'b0, 4'h3, 4'b1000});

        foreach (tbl[i]) begin
            mdrop = tbl[i].ma;
            tick(tbl[i].di, tbl[i].cmd, tbl[i].rst_n);
            check("table", outs(), tbl[i].exp);
        end

        // Line reset: a run of 15 ones is broken by a 0, the next run of 16 disconnects.
        for (int i = 0; i < DISC_LEN - 1; i++) tick(1'b1, 1'b0, 1'b1);
        check("lr_first_run", outs(), 4'b1000);
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DISC_LEN - 1; i++) tick(1'b1, 1'b0, 1'b1);
        check("lr_15_of_2nd", outs(), 4'b1000);
        tick(1'b1, 1'b0, 1'b1);
        check("lr_disc", outs(), 4'b0010);
        tick(1'b0, 1'b0, 1'b1);
        check("lr_after", outs(), 4'b0000);

        // Command and line reset on the same edge.
        mdrop = 4'h3;
        send_bits(mw, 0, MAGIC_LEN - 1);
        send_bits(64'h3, 0, ADDR_W - 1);
        check("simul_conn", outs(), 4'b1100);
        tick(1'b0, 1'b0, 1'b1);
        check("cn_one_cycle", outs(), 4'b1000);
        for (int i = 0; i < DISC_LEN - 1; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        check("simul_disc", outs(), 4'b0010);
        tick(1'b1, 1'b1, 1'b1);
        check("simul_single", outs(), 4'b0000);

        // Address mismatch, then an immediate retry.
        tick(1'b0, 1'b0, 1'b1);
        send_bits(mw, 0, MAGIC_LEN - 1);
        send_bits(64'h5, 0, ADDR_W - 1);
        check("mm_pulse", outs(), 4'b0001);
        send_bits(mw, 0, 0);
        check("mm_one_cycle", outs(), 4'b0000);
        send_bits(mw, 1, MAGIC_LEN - 1);
        send_bits(64'h3, 0, ADDR_W - 1);
        check("retry_conn", outs(), 4'b1100);
        tick(1'b0, 1'b1, 1'b1);
        check("cmd_disc", outs(), 4'b0010);

        // Reset after two address bits aborts the connect attempt.
        send_bits(mw, 0, MAGIC_LEN - 1);
        send_bits(64'h3, 0, 1);
        tick(1'b0, 1'b0, 1'b0);
        check("rst_abort", outs(), 4'b0000);
        send_bits(64'h3, 2, 3);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
        check("rst_no_conn", outs(), 4'b0000);
        send_bits(mw, 0, MAGIC_LEN - 1);
        send_bits(64'h3, 0, ADDR_W - 1);
        check("rst_recover", outs(), 4'b1100);
        tick(1'b0, 1'b1, 1'b1);

        // Near-miss magic (bit 17 inverted) must not open the address phase.
        mw[17] = ~mw[17];
        send_bits(mw, 0, MAGIC_LEN - 1);
        send_bits(64'h3, 0, ADDR_W - 1);
        check("near_miss", outs(), 4'b0000);
        tick(1'b0, 1'b1, 1'b1);
        check("idle_cmd", outs(), 4'b0000);
        mw[17] = ~mw[17];

        // Randomized episodes against the model.
        for (int ep = 0; ep < 60; ep++) begin
            logic [63:0] rm;
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) begin
                mdrop = 4'($urandom);
                tick(1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b1);
            end
            rm = mw;
            if ($urandom_range(0, 4) == 0) rm[$urandom_range(0, MAGIC_LEN - 1)] ^= 1'b1;
            for (int i = 0; i < MAGIC_LEN; i++)
                tick(rm[i], 1'($urandom), 1'($urandom_range(0, 199) != 0));
            a = 4'($urandom);
            for (int i = 0; i < ADDR_W; i++) begin
                if (i == ADDR_W - 1) mdrop = ($urandom_range(0, 2) != 0) ? a : 4'($urandom);
                else mdrop = 4'($urandom);
                tick(a[i], 1'($urandom), 1'b1);
            end
            n = $urandom_range(0, 40);
            for (int i = 0; i < n; i++)
                tick(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 39) == 0),
                     1'($urandom_range(0, 99) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
